// File: rtl/phe_multi.sv
// phe_multi: TSN test-packet header extender producing 134b FAST packets (metadata, header+timestamp, sequence, padding).
// Build option PHE_SLOT_TAG_EN: when defined, the sequence beat carries slot_shift_cnt/slot_ID; otherwise those bits are 0.
module phe_multi #(
  parameter int N_FLOWS   = 8,
  parameter int LEN_W     = 12,
  parameter int HDR_BEATS = 4,
  parameter int TS_W      = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cnt_rst,
  input  logic                       in_req_valid,
  input  logic [$clog2(N_FLOWS)-1:0] in_req_flow,
  output logic                       out_req_ready,
  output logic                       out_req_drop,
  input  logic [N_FLOWS*LEN_W-1:0]   in_flow_len,
  output logic [N_FLOWS*32-1:0]      out_flow_cnt,
  input  logic [TS_W-1:0]            timestamp,
  input  logic [3:0]                 slot_shift_cnt,
  input  logic [8:0]                 slot_ID,
  input  logic [127:0]               in_hdr_data,
  input  logic                       in_hdr_wr,
  output logic                       out_hdr_drop,
  input  logic                       in_out_alf,
  output logic [133:0]               out_data,
  output logic                       out_data_wr,
  output logic                       out_data_valid,
  output logic                       out_data_valid_wr
);

  localparam int HW = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam logic [LEN_W-1:0] L_MIN = LEN_W'((HDR_BEATS + 1) * 16);
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'((1 << LEN_W) - 33);
  localparam logic [HW-1:0]    HDR_LAST = HW'(HDR_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_CAP, S_WAIT, S_MD0, S_MD1, S_HDR, S_SEQ, S_PAD
  } state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic               req_drop_q, req_drop_d;
  logic               hdr_drop_q, hdr_drop_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        seq_q, seq_d;
  logic [HW-1:0]      hdr_idx_q, hdr_idx_d;
  logic [LEN_W-1:0]   pad_cnt_q, pad_cnt_d;
  logic [127:0]       hdr_buf_q [HDR_BEATS];
  logic [127:0]       hdr_buf_d [HDR_BEATS];
  logic [31:0]        cnt_q [N_FLOWS];
  logic [31:0]        cnt_d [N_FLOWS];
  logic [133:0]       out_data_q, out_data_d;
  logic               out_wr_q, out_wr_d;
  logic               valid_q, valid_d;
  logic               valid_wr_q, valid_wr_d;

  logic [31:0]        req_idx32;
  logic               req_in_range;
  logic               accept;
  logic               bad_req;
  logic [LEN_W-1:0]   len_raw;
  logic [LEN_W:0]     frame_beats;
  logic [LEN_W:0]     pad_beats;
  logic [3:0]         tail_inv;
  logic [19:0]        slot_tag;
  logic [127:0]       hdr_beat;
  logic [127:0]       md0_data;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < L_MIN)      return L_MIN;
    else if (l > L_MAX) return L_MAX;
    else                return l;
  endfunction

`ifdef PHE_SLOT_TAG_EN
  assign slot_tag = {slot_shift_cnt, 7'd0, slot_ID};
`else
  logic unused_slot;
  assign unused_slot = ^{slot_shift_cnt, slot_ID};
  assign slot_tag    = 20'd0;
`endif

  assign req_idx32    = 32'(in_req_flow);
  assign req_in_range = (req_idx32 < 32'(N_FLOWS));
  assign accept       = in_req_valid && ready_q && req_in_range;
  assign bad_req      = in_req_valid && ready_q && !req_in_range;

  // Frame geometry derived from the latched, already clamped length.
  assign frame_beats = ({1'b0, len_q} + (LEN_W+1)'(15)) >> 4;
  assign pad_beats   = frame_beats - (LEN_W+1)'(HDR_BEATS + 1);
  assign tail_inv    = 4'(5'd16 - {1'b0, len_q[3:0]});

  always_comb begin
    len_raw = '0;
    for (int i = 0; i < N_FLOWS; i++) begin
      if (32'(i) == req_idx32) len_raw = in_flow_len[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    md0_data = '0;
    md0_data[96 +: LEN_W] = len_q + LEN_W'(32);
  end

  always_comb begin
    hdr_beat = hdr_buf_q[hdr_idx_q];
    if (hdr_idx_q == HDR_LAST) hdr_beat[TS_W-1:0] = timestamp;
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    seq_d      = seq_q;
    hdr_idx_d  = hdr_idx_q;
    pad_cnt_d  = pad_cnt_q;
    hdr_buf_d  = hdr_buf_q;
    req_drop_d = 1'b0;
    hdr_drop_d = in_hdr_wr && (state_q != S_HDR_CAP);
    out_data_d = '0;
    out_wr_d   = 1'b0;
    valid_d    = 1'b0;
    valid_wr_d = 1'b0;

    // Clear wins over the old value; a same-cycle accepted request then counts from zero.
    for (int i = 0; i < N_FLOWS; i++) begin
      cnt_d[i] = cnt_rst ? 32'd0 : cnt_q[i];
      if (accept && (32'(i) == req_idx32)) begin
        cnt_d[i] = cnt_d[i] + 32'd1;
        seq_d    = cnt_d[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d     = clamp_len(len_raw);
          hdr_idx_d = '0;
          state_d   = S_HDR_CAP;
        end else if (bad_req) begin
          req_drop_d = 1'b1;
        end
      end
      S_HDR_CAP: begin
        if (in_hdr_wr) begin
          hdr_buf_d[hdr_idx_q] = in_hdr_data;
          if (hdr_idx_q == HDR_LAST) begin
            hdr_idx_d = '0;
            state_d   = S_WAIT;
          end else begin
            hdr_idx_d = hdr_idx_q + HW'(1);
          end
        end
      end
      S_WAIT: begin
        if (!in_out_alf) state_d = S_MD0;
      end
      S_MD0: begin
        out_wr_d   = 1'b1;
        out_data_d = {2'b01, 4'd0, md0_data};
        state_d    = S_MD1;
      end
      S_MD1: begin
        out_wr_d   = 1'b1;
        out_data_d = {2'b11, 4'd0, 128'd0};
        hdr_idx_d  = '0;
        state_d    = S_HDR;
      end
      S_HDR: begin
        out_wr_d   = 1'b1;
        out_data_d = {2'b11, 4'd0, hdr_beat};
        if (hdr_idx_q == HDR_LAST) begin
          hdr_idx_d = '0;
          state_d   = S_SEQ;
        end else begin
          hdr_idx_d = hdr_idx_q + HW'(1);
        end
      end
      S_SEQ: begin
        out_wr_d = 1'b1;
        if (pad_beats == '0) begin
          out_data_d = {2'b10, tail_inv, seq_q, 76'd0, slot_tag};
          valid_d    = 1'b1;
          valid_wr_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          out_data_d = {2'b11, 4'd0, seq_q, 76'd0, slot_tag};
          pad_cnt_d  = LEN_W'(pad_beats - (LEN_W+1)'(1));
          state_d    = S_PAD;
        end
      end
      S_PAD: begin
        out_wr_d = 1'b1;
        if (pad_cnt_q == '0) begin
          out_data_d = {2'b10, tail_inv, 128'd0};
          valid_d    = 1'b1;
          valid_wr_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          out_data_d = {2'b11, 4'd0, 128'd0};
          pad_cnt_d  = pad_cnt_q - LEN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      req_drop_q <= 1'b0;
      hdr_drop_q <= 1'b0;
      len_q      <= '0;
      seq_q      <= '0;
      hdr_idx_q  <= '0;
      pad_cnt_q  <= '0;
      hdr_buf_q  <= '{default: '0};
      cnt_q      <= '{default: '0};
      out_data_q <= '0;
      out_wr_q   <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      req_drop_q <= req_drop_d;
      hdr_drop_q <= hdr_drop_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      hdr_idx_q  <= hdr_idx_d;
      pad_cnt_q  <= pad_cnt_d;
      hdr_buf_q  <= hdr_buf_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_wr_q   <= out_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
    end
  end

  for (genvar g = 0; g < N_FLOWS; g++) begin : g_cnt_out
    assign out_flow_cnt[g*32 +: 32] = cnt_q[g];
  end

  assign out_req_ready     = ready_q;
  assign out_req_drop      = req_drop_q;
  assign out_hdr_drop      = hdr_drop_q;
  assign out_data          = out_data_q;
  assign out_data_wr       = out_wr_q;
  assign out_data_valid    = valid_q;
  assign out_data_valid_wr = valid_wr_q;

endmodule

// File: tb/tb_phe_multi.sv
// Bench for phe_multi: directed scenarios plus randomized packets checked against a rule-based packet model.
module tb_phe_multi;
  localparam int NF   = 6;
  localparam int LW   = 12;
  localparam int HB   = 4;
  localparam int TW   = 48;
  localparam int LMIN = (HB + 1) * 16;
  localparam int LMAX = (1 << LW) - 33;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cnt_rst;
  logic            in_req_valid;
  logic [2:0]      in_req_flow;
  logic            out_req_ready;
  logic            out_req_drop;
  logic [NF*LW-1:0] in_flow_len;
  logic [NF*32-1:0] out_flow_cnt;
  logic [TW-1:0]   ts = 48'h1234_5678_9ABC;
  logic [3:0]      slot_shift_cnt;
  logic [8:0]      slot_ID;
  logic [127:0]    in_hdr_data;
  logic            in_hdr_wr;
  logic            out_hdr_drop;
  logic            in_out_alf;
  logic [133:0]    out_data;
  logic            out_data_wr;
  logic            out_data_valid;
  logic            out_data_valid_wr;

  phe_multi #(.N_FLOWS(NF), .LEN_W(LW), .HDR_BEATS(HB), .TS_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_rst(cnt_rst),
    .in_req_valid(in_req_valid), .in_req_flow(in_req_flow),
    .out_req_ready(out_req_ready), .out_req_drop(out_req_drop),
    .in_flow_len(in_flow_len), .out_flow_cnt(out_flow_cnt),
    .timestamp(ts), .slot_shift_cnt(slot_shift_cnt), .slot_ID(slot_ID),
    .in_hdr_data(in_hdr_data), .in_hdr_wr(in_hdr_wr), .out_hdr_drop(out_hdr_drop),
    .in_out_alf(in_out_alf), .out_data(out_data), .out_data_wr(out_data_wr),
    .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts <= ts + 48'd1;

  int          nchecks = 0;
  int          nerrs   = 0;
  int unsigned mcnt [NF];
  int          flow_len [NF];
  int          exp_len;
  int unsigned exp_seq;
  logic [127:0] hdr [HB];
  logic [3:0]  cur_shift;
  logic [8:0]  cur_slot;
  logic [133:0] gq [$];
  logic [TW-1:0] tq [$];
  logic [1:0]  fq [$];
  int          cq [$];

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int l);
    if (l < LMIN) return LMIN;
    if (l > LMAX) return LMAX;
    return l;
  endfunction

  task automatic set_len(input int f, input int l);
    flow_len[f] = l;
    in_flow_len[f*LW +: LW] = LW'(l);
  endtask

  task automatic check_cnts(input string nm);
    for (int i = 0; i < NF; i++)
      check($sformatf("%s_cnt%0d", nm, i), 134'(out_flow_cnt[i*32 +: 32]), 134'(mcnt[i]));
  endtask

  task automatic do_request(input int flow, input bit with_rst);
    int n = 0;
    while (out_req_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 134'(out_req_ready), 134'd1);
    cur_shift = 4'($urandom);
    cur_slot  = 9'($urandom);
    slot_shift_cnt = cur_shift;
    slot_ID        = cur_slot;
    in_req_valid = 1'b1;
    in_req_flow  = 3'(flow);
    cnt_rst      = with_rst;
    @(negedge clk);
    in_req_valid = 1'b0;
    cnt_rst      = 1'b0;
    if (with_rst) for (int i = 0; i < NF; i++) mcnt[i] = 0;
    if (flow < NF) begin
      mcnt[flow] = mcnt[flow] + 1;
      exp_seq = mcnt[flow];
      exp_len = clamp(flow_len[flow]);
    end
  endtask

  task automatic send_hdr(input bit gaps);
    for (int b = 0; b < HB; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      hdr[b] = {$urandom, $urandom, $urandom, $urandom};
      in_hdr_wr   = 1'b1;
      in_hdr_data = hdr[b];
      @(negedge clk);
      in_hdr_wr = 1'b0;
    end
  endtask

  task automatic collect(input bit rand_alf, input int budget, output int first);
    gq.delete(); tq.delete(); fq.delete(); cq.delete();
    first = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (out_data_wr) begin
        gq.push_back(out_data);
        tq.push_back(ts - 48'd1);
        fq.push_back({out_data_valid, out_data_valid_wr});
        cq.push_back(c);
        if (first < 0) first = c;
        if (rand_alf) in_out_alf = 1'($urandom);
      end
      if (out_data_valid_wr) break;
    end
    in_out_alf = 1'b0;
  endtask

  task automatic compare_pkt(input string nm);
    int F = (exp_len + 15) / 16;
    int P = F - HB - 1;
    logic [3:0] inv = 4'((16 - exp_len % 16) % 16);
    logic [133:0] e [$];
    logic [127:0] d;
    logic [19:0] tag;
    int last;
`ifdef PHE_SLOT_TAG_EN
    tag = {cur_shift, 7'd0, cur_slot};
`else
    tag = 20'd0;
`endif
    d = 128'(exp_len + 32) << 96;
    e.push_back({2'b01, 4'd0, d});
    e.push_back({2'b11, 4'd0, 128'd0});
    for (int b = 0; b < HB; b++) begin
      d = hdr[b];
      if (b == HB - 1) d[TW-1:0] = (gq.size() > 2 + b) ? tq[2 + b] : '0;
      e.push_back({2'b11, 4'd0, d});
    end
    if (P == 0) e.push_back({2'b10, inv, exp_seq, 76'd0, tag});
    else        e.push_back({2'b11, 4'd0, exp_seq, 76'd0, tag});
    for (int p = 0; p < P; p++)
      e.push_back((p == P - 1) ? {2'b10, inv, 128'd0} : {2'b11, 4'd0, 128'd0});
    check({nm, "_nbeats"}, 134'(gq.size()), 134'(F + 2));
    last = gq.size() - 1;
    for (int i = 0; i < gq.size() && i < e.size(); i++) begin
      check($sformatf("%s_beat%0d", nm, i), gq[i], e[i]);
      check($sformatf("%s_vflags%0d", nm, i), 134'(fq[i]), (i == F + 1) ? 134'd3 : 134'd0);
    end
    if (last > 0) check({nm, "_b2b"}, 134'(cq[last] - cq[0]), 134'(last));
  endtask

  task automatic run_pkt(input string nm, input int flow, input int len, input bit gaps, input bit ralf);
    int first;
    set_len(flow, len);
    do_request(flow, 1'b0);
    send_hdr(gaps);
    collect(ralf, 600, first);
    check({nm, "_lat"}, 134'(first), 134'd2);
    compare_pkt(nm);
  endtask

  initial begin
    int first;
    int wrs;
    int seen;
    rst_n = 1'b0; cnt_rst = 1'b0; in_req_valid = 1'b0; in_req_flow = '0;
    in_flow_len = '0; slot_shift_cnt = '0; slot_ID = '0; in_hdr_data = '0;
    in_hdr_wr = 1'b0; in_out_alf = 1'b0; cur_shift = '0; cur_slot = '0;
    exp_len = 0; exp_seq = 0;
    for (int i = 0; i < NF; i++) begin mcnt[i] = 0; flow_len[i] = 0; end

    repeat (3) @(negedge clk);
    check("rst_data", out_data, 134'd0);
    check("rst_ctl", {129'd0, out_data_wr, out_data_valid, out_data_valid_wr, out_req_drop, out_hdr_drop}, 134'd0);
    check("rst_ready", 134'(out_req_ready), 134'd0);
    check_cnts("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 134'(out_req_ready), 134'd1);

    run_pkt("f2_len100", 2, 100, 1'b0, 1'b0);
    check_cnts("after_f2");
    run_pkt("f5_len80", 5, 80, 1'b0, 1'b0);
    run_pkt("f5_len40", 5, 40, 1'b0, 1'b0);
    check_cnts("after_f5");

    // Downstream almost-full held after the header, plus one surplus header beat.
    in_out_alf = 1'b1;
    set_len(0, 150);
    do_request(0, 1'b0);
    send_hdr(1'b0);
    in_hdr_wr = 1'b1; in_hdr_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_hdr_wr = 1'b0;
    check("extra_hdr_drop", 134'(out_hdr_drop), 134'd1);
    wrs = 0;
    repeat (19) begin
      @(negedge clk);
      if (out_data_wr) wrs++;
    end
    check("alf_hold_nowr", 134'(wrs), 134'd0);
    in_out_alf = 1'b0;
    collect(1'b0, 600, first);
    check("alf_release_lat", 134'(first), 134'd2);
    compare_pkt("alf_pkt");

    // Stray header beat while idle.
    in_hdr_wr = 1'b1; in_hdr_data = '1;
    @(negedge clk);
    in_hdr_wr = 1'b0;
    check("idle_hdr_drop", 134'(out_hdr_drop), 134'd1);
    @(negedge clk);
    check("idle_hdr_drop_end", 134'(out_hdr_drop), 134'd0);

    // Out-of-range flow indices.
    for (int f = 6; f < 8; f++) begin
      do_request(f, 1'b0);
      check($sformatf("drop_f%0d", f), 134'(out_req_drop), 134'd1);
      wrs = 0;
      repeat (5) begin
        @(negedge clk);
        if (out_data_wr) wrs++;
      end
      check($sformatf("drop_end_f%0d", f), 134'(out_req_drop), 134'd0);
      check($sformatf("drop_ready_f%0d", f), 134'(out_req_ready), 134'd1);
      check($sformatf("drop_nopkt_f%0d", f), 134'(wrs), 134'd0);
    end
    check_cnts("after_drop");

    // Bring flow3 to 7, then clear counters in the same cycle as a flow3 request.
    while (mcnt[3] < 7) run_pkt("f3_fill", 3, $urandom_range(0, 120), 1'b1, 1'b0);
    check_cnts("f3_at7");
    set_len(3, 96);
    do_request(3, 1'b1);
    send_hdr(1'b0);
    collect(1'b0, 600, first);
    compare_pkt("f3_cntrst");
    check("f3_cntrst_seq", 134'(exp_seq), 134'd1);
    check_cnts("after_cntrst");

    // Counter clear while a packet waits: latched sequence survives.
    in_out_alf = 1'b1;
    set_len(4, 120);
    do_request(4, 1'b0);
    send_hdr(1'b0);
    cnt_rst = 1'b1;
    @(negedge clk);
    cnt_rst = 1'b0;
    for (int i = 0; i < NF; i++) mcnt[i] = 0;
    check_cnts("midpkt_clear");
    in_out_alf = 1'b0;
    collect(1'b0, 600, first);
    compare_pkt("f4_midclear");

    for (int k = 0; k < 8; k++)
      run_pkt($sformatf("rnd%0d", k), $urandom_range(0, NF - 1),
              (k == 7) ? 4095 : $urandom_range(0, 400), 1'b1, 1'b1);
    check_cnts("after_rnd");

    // Asynchronous reset during padding truncates the packet.
    set_len(1, 200);
    do_request(1, 1'b0);
    send_hdr(1'b0);
    seen = 0;
    for (int c = 0; c < 40 && seen < 8; c++) begin
      @(negedge clk);
      if (out_data_wr) seen++;
    end
    check("pre_rst_beats", 134'(seen), 134'd8);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data", out_data, 134'd0);
    check("midrst_ctl", {130'd0, out_data_wr, out_data_valid, out_data_valid_wr, out_req_ready}, 134'd0);
    wrs = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_data_wr || out_data_valid_wr) wrs++;
    end
    check("midrst_notail", 134'(wrs), 134'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NF; i++) mcnt[i] = 0;
    check_cnts("post_rst");
    run_pkt("f1_after_rst", 1, 100, 1'b0, 1'b0);
    check("f1_after_rst_seq", 134'(exp_seq), 134'd1);
    check_cnts("final");

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end
endmodule
